// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access path: access sizes, DMEM command codes,
// lock FSM states and the range/command helpers used by the arbiter.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] RWE_RD = 2'd0;
  localparam logic [1:0] RWE_SW = 2'd1;
  localparam logic [1:0] RWE_SH = 2'd2;
  localparam logic [1:0] RWE_SB = 2'd3;

  localparam int DMEM_BYTES = 128;

  typedef enum logic {
    S_RR,
    S_LOCK
  } lock_state_t;

  // Unaligned accesses are fine as long as the last byte stays inside DMEM.
  function automatic logic access_legal(input logic [1:0] size, input logic [6:0] addr);
    logic [7:0] end_addr;
    end_addr = {1'b0, addr} + (8'd1 << size);
    return (size != 2'd3) && (end_addr <= 8'(DMEM_BYTES));
  endfunction

  function automatic logic [1:0] store_rwe(input logic [1:0] size);
    logic [1:0] rwe;
    case (size)
      SZ_B:    rwe = RWE_SB;
      SZ_H:    rwe = RWE_SH;
      SZ_W:    rwe = RWE_SW;
      default: rwe = RWE_RD;
    endcase
    return rwe;
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Load data formatter: picks byte/half/word from the low end of the raw DMEM word and
// sign- or zero-extends it. Also used by the core writeback path.
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SZ_B:    data = uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_H:    data = uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with a bounded port-1 burst lock in front of DMEM,
// translating grants into rwe/addr/wdata and returning formatted responses one cycle later.
//
// state  | meaning
// S_RR   | plain round-robin between the two ports
// S_LOCK | port 1 holds a burst lock; port 0 forced in after LOCK_MAX port-1 grants
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic        m0_unsigned,
  input  logic [6:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic        m1_unsigned,
  input  logic [6:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [1:0]  mem_rwe,
  output logic [6:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  lock_state_t   state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rr_q, rr_d;
  logic          pick1, any_gnt, legal;

  logic          sel_we, sel_uns;
  logic [1:0]    sel_size;
  logic [6:0]    sel_addr;
  logic [31:0]   sel_wdata;

  logic          rsp_valid, rsp_port, rsp_we, rsp_uns, rsp_err;
  logic [1:0]    rsp_size;
  logic [31:0]   fmt_data, rsp_data;

  // Arbitration: single requester wins outright, ties go by lock state or rr.
  always_comb begin
    pick1  = 1'b0;
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        if (state_q == S_LOCK && m1_lock) pick1 = (lock_cnt_q != CNT_MAX);
        else if (state_q == S_LOCK)       pick1 = 1'b0;
        else                              pick1 = rr_q;
        m1_gnt = pick1;
        m0_gnt = !pick1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign any_gnt = m0_gnt || m1_gnt;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rr_d       = rr_q;
    if (m0_gnt) rr_d = 1'b1;
    if (m1_gnt) rr_d = 1'b0;
    case (state_q)
      S_RR: begin
        if (m1_gnt && m1_lock) begin
          state_d    = S_LOCK;
          lock_cnt_d = CW'(1);
        end
      end
      S_LOCK: begin
        if (!m1_lock) begin
          state_d    = S_RR;
          lock_cnt_d = '0;
          if (!any_gnt) rr_d = 1'b0;
        end else if (m1_gnt) begin
          // Saturate so a late port-0 request is still let in at the bound.
          if (lock_cnt_q != CNT_MAX) lock_cnt_d = lock_cnt_q + CW'(1);
        end else if (m0_gnt && lock_cnt_q == CNT_MAX) begin
          lock_cnt_d = '0;
        end
      end
      default: state_d = S_RR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RR;
      lock_cnt_q <= '0;
      rr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rr_q       <= rr_d;
    end
  end

  always_comb begin
    sel_we    = m1_gnt ? m1_we       : m0_we;
    sel_uns   = m1_gnt ? m1_unsigned : m0_unsigned;
    sel_size  = m1_gnt ? m1_size     : m0_size;
    sel_addr  = m1_gnt ? m1_addr     : m0_addr;
    sel_wdata = m1_gnt ? m1_wdata    : m0_wdata;
    legal     = access_legal(sel_size, sel_addr);
  end

  // Illegal or idle cycles collapse to a read of address 0 so DMEM never sees a stray store.
  always_comb begin
    mem_rwe   = RWE_RD;
    mem_addr  = '0;
    mem_wdata = '0;
    if (any_gnt && legal) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      if (sel_we) mem_rwe = store_rwe(sel_size);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_port  <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_size  <= SZ_B;
      rsp_uns   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= any_gnt;
      rsp_port  <= m1_gnt;
      rsp_we    <= sel_we;
      rsp_size  <= sel_size;
      rsp_uns   <= sel_uns;
      rsp_err   <= !legal;
    end
  end

  dmem_load_fmt u_fmt (
    .size (rsp_size),
    .uns  (rsp_uns),
    .raw  (mem_rdata),
    .data (fmt_data)
  );

  assign rsp_data  = (rsp_we || rsp_err) ? 32'b0 : fmt_data;

  assign m0_rvalid = !reset && rsp_valid && !rsp_port;
  assign m1_rvalid = !reset && rsp_valid &&  rsp_port;
  assign m0_rdata  = m0_rvalid ? rsp_data : 32'b0;
  assign m1_rdata  = m1_rvalid ? rsp_data : 32'b0;
  assign m0_err    = m0_rvalid && rsp_err;
  assign m1_err    = m1_rvalid && rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-array DMEM model behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_unsigned;
  logic [1:0]  m0_size;
  logic [6:0]  m0_addr;
  logic [31:0] m0_wdata;
  logic        m1_req, m1_we, m1_unsigned, m1_lock;
  logic [1:0]  m1_size;
  logic [6:0]  m1_addr;
  logic [31:0] m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  mem_rwe;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        init_mem;
  logic [7:0]  dm [128];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        e1;

  always #5 clk = ~clk;

  dmem_arbiter #(.LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_unsigned(m1_unsigned),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_rwe(mem_rwe), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // DMEM: little-endian byte array, registered read, stores applied at the clock edge.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 128; i++) dm[i] <= 8'h00;
      dm[4] <= 8'd16;
    end else begin
      case (mem_rwe)
        2'd1: begin
          dm[mem_addr]        <= mem_wdata[7:0];
          dm[mem_addr + 7'd1] <= mem_wdata[15:8];
          dm[mem_addr + 7'd2] <= mem_wdata[23:16];
          dm[mem_addr + 7'd3] <= mem_wdata[31:24];
        end
        2'd2: begin
          dm[mem_addr]        <= mem_wdata[7:0];
          dm[mem_addr + 7'd1] <= mem_wdata[15:8];
        end
        2'd3: dm[mem_addr] <= mem_wdata[7:0];
        default: ;
      endcase
    end
    mem_rdata <= {dm[mem_addr + 7'd3], dm[mem_addr + 7'd2], dm[mem_addr + 7'd1], dm[mem_addr]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic req, input logic we, input logic [1:0] size,
                      input logic uns, input logic [6:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_size = size; m0_unsigned = uns;
    m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [1:0] size,
                      input logic uns, input logic [6:0] addr, input logic [31:0] wdata,
                      input logic lock);
    m1_req = req; m1_we = we; m1_size = size; m1_unsigned = uns;
    m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
  endtask

  task automatic idle();
    drv0(0, 0, 2'd0, 0, 7'd0, 32'd0);
    drv1(0, 0, 2'd0, 0, 7'd0, 32'd0, 0);
  endtask

  initial begin
    reset = 1'b1;
    init_mem = 1'b1;
    drv0(1, 0, 2'd2, 0, 7'd4, 32'd0);
    drv1(1, 1, 2'd2, 0, 7'd8, 32'h1234_5678, 0);
    cyc(); cyc(); #2;
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_gnt1", m1_gnt, 0);
    chk("rst_rvalid0", m0_rvalid, 0);
    chk("rst_rvalid1", m1_rvalid, 0);
    chk("rst_mem_rwe", mem_rwe, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    cyc(); reset = 1'b0; init_mem = 1'b0; idle(); #2;
    chk("post_rst_rvalid0", m0_rvalid, 0);
    chk("post_rst_rdata0", m0_rdata, 0);
    chk("post_rst_err1", m1_err, 0);

    // port-0 load word at 4
    cyc(); drv0(1, 0, 2'd2, 0, 7'd4, 32'd0); #2;
    chk("lw4_gnt0", m0_gnt, 1);
    chk("lw4_gnt1", m1_gnt, 0);
    chk("lw4_rwe", mem_rwe, 0);
    chk("lw4_addr", mem_addr, 4);
    cyc(); idle(); #2;
    chk("lw4_rvalid0", m0_rvalid, 1);
    chk("lw4_rdata0", m0_rdata, 32'd16);
    chk("lw4_err0", m0_err, 0);
    chk("lw4_rvalid1", m1_rvalid, 0);

    // port-1 load word at 4 (also moves rr back to port 0)
    cyc(); drv1(1, 0, 2'd2, 0, 7'd4, 32'd0, 0); #2;
    chk("p1lw_gnt1", m1_gnt, 1);
    cyc(); idle(); #2;
    chk("p1lw_rvalid1", m1_rvalid, 1);
    chk("p1lw_rdata1", m1_rdata, 32'd16);
    chk("p1lw_err1", m1_err, 0);
    chk("p1lw_rvalid0", m0_rvalid, 0);

    // both store bytes every cycle: 0,1,0,1
    cyc();
    drv0(1, 1, 2'd0, 0, 7'h20, 32'h0000_00A5);
    drv1(1, 1, 2'd0, 0, 7'h21, 32'h0000_005A, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      #2;
      chk("sb_gnt0", m0_gnt, (k % 2 == 0));
      chk("sb_gnt1", m1_gnt, (k % 2 == 1));
      chk("sb_rwe", mem_rwe, 3);
      chk("sb_addr", mem_addr, (k % 2 == 0) ? 7'h20 : 7'h21);
      chk("sb_wdata", mem_wdata, (k % 2 == 0) ? 32'hA5 : 32'h5A);
      if (k > 0) begin
        chk("sb_rvalid0", m0_rvalid, (k % 2 == 1));
        chk("sb_rvalid1", m1_rvalid, (k % 2 == 0));
      end
    end
    cyc(); idle(); #2;
    chk("sb_last_rvalid1", m1_rvalid, 1);
    chk("sb_last_rdata1", m1_rdata, 0);
    chk("sb_last_rvalid0", m0_rvalid, 0);

    // read back the two stored bytes as one unsigned half at 0x20
    cyc(); drv0(1, 0, 2'd1, 1, 7'h20, 32'd0); #2;
    chk("lh20_gnt0", m0_gnt, 1);
    cyc(); idle(); #2;
    chk("lh20_rdata0", m0_rdata, 32'h0000_5AA5);

    // store half 0x8001 at 0x10, then signed/unsigned half and signed byte loads
    cyc(); drv0(1, 1, 2'd1, 0, 7'h10, 32'h0000_8001); #2;
    chk("sh_gnt0", m0_gnt, 1);
    chk("sh_rwe", mem_rwe, 2);
    chk("sh_addr", mem_addr, 7'h10);
    chk("sh_wdata", mem_wdata, 32'h8001);
    cyc(); drv0(1, 0, 2'd1, 0, 7'h10, 32'd0); #2;
    chk("sh_ack_rvalid0", m0_rvalid, 1);
    chk("sh_ack_rdata0", m0_rdata, 0);
    chk("lhs_rwe", mem_rwe, 0);
    cyc(); drv0(1, 0, 2'd1, 1, 7'h10, 32'd0); #2;
    chk("lhs_rdata0", m0_rdata, 32'hFFFF_8001);
    cyc(); drv0(1, 0, 2'd0, 0, 7'h11, 32'd0); #2;
    chk("lhu_rdata0", m0_rdata, 32'h0000_8001);
    cyc(); idle(); #2;
    chk("lbs_rdata0", m0_rdata, 32'hFFFF_FF80);

    // range boundaries: word at 124 legal, word at 126 illegal, store word at 126 blocked
    cyc(); drv0(1, 0, 2'd2, 0, 7'd124, 32'd0); #2;
    chk("lw124_rwe", mem_rwe, 0);
    cyc(); drv0(1, 0, 2'd2, 0, 7'd126, 32'd0); #2;
    chk("lw124_err0", m0_err, 0);
    chk("lw126_gnt0", m0_gnt, 1);
    chk("lw126_rwe", mem_rwe, 0);
    cyc(); drv0(1, 1, 2'd2, 0, 7'd126, 32'hDEAD_BEEF); #2;
    chk("lw126_rvalid0", m0_rvalid, 1);
    chk("lw126_err0", m0_err, 1);
    chk("lw126_rdata0", m0_rdata, 0);
    chk("sw126_gnt0", m0_gnt, 1);
    chk("sw126_rwe", mem_rwe, 0);
    cyc(); drv0(1, 1, 2'd3, 0, 7'd0, 32'hFFFF_FFFF); #2;
    chk("sw126_err0", m0_err, 1);
    chk("sz3_rwe", mem_rwe, 0);
    cyc(); idle(); #2;
    chk("sz3_err0", m0_err, 1);
    chk("sz3_rdata0", m0_rdata, 0);

    // lock burst: rr now points at port 1, so the burst starts right away
    cyc();
    drv0(1, 0, 2'd0, 0, 7'd0, 32'd0);
    drv1(1, 0, 2'd0, 0, 7'd1, 32'd0, 1);
    for (int c = 0; c < 15; c++) begin
      if (c > 0) cyc();
      if (c == 12) m1_lock = 1'b0;
      #2;
      e1 = (c < 8) || (c > 8 && c < 12) || (c == 13);
      chk("lock_gnt1", m1_gnt, e1);
      chk("lock_gnt0", m0_gnt, !e1);
    end

    // reset the cycle after a port-0 load grant
    cyc(); idle(); #2;
    cyc(); drv0(1, 0, 2'd2, 0, 7'd4, 32'd0); #2;
    chk("rl_gnt0", m0_gnt, 1);
    cyc(); reset = 1'b1; drv1(1, 0, 2'd2, 0, 7'd4, 32'd0, 0); #2;
    chk("rl_rvalid0", m0_rvalid, 0);
    chk("rl_rdata0", m0_rdata, 0);
    chk("rl_gnt0_in_rst", m0_gnt, 0);
    chk("rl_gnt1_in_rst", m1_gnt, 0);
    chk("rl_rwe_in_rst", mem_rwe, 0);
    cyc(); reset = 1'b0; idle(); #2;
    chk("rl_post_rvalid0", m0_rvalid, 0);
    chk("rl_post_rvalid1", m1_rvalid, 0);
    chk("rl_post_addr", mem_addr, 0);
    cyc();
    drv0(1, 0, 2'd2, 0, 7'd4, 32'd0);
    drv1(1, 0, 2'd2, 0, 7'd8, 32'd0, 0);
    #2;
    chk("rl_tie_gnt0", m0_gnt, 1);
    chk("rl_tie_gnt1", m1_gnt, 0);
    cyc(); idle(); #2;
    chk("rl_tie_rdata0", m0_rdata, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
